// File: rtl/nrisc_pkg.sv
// Shared nRISC definitions: datapath widths, the EX/MEM entry layout and
// the ULA_Control encodings that decode and the EX/MEM register agree on.
package nrisc_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 2;

    // ULA_Control: only ULA_SLT instructions drive in_set_cond high.
    typedef enum logic [1:0] {
        ULA_ADD = 2'b00,
        ULA_SUB = 2'b01,
        ULA_SLT = 2'b10,
        ULA_NOT = 2'b11
    } ula_ctrl_t;

    // Payload carried from execute to memory/write-back.
    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     store_data;
    } ex_mem_entry_t;

    localparam int ENTRY_W = $bits(ex_mem_entry_t);

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry skid buffer. in_ready comes only from the registered
// occupancy, so a downstream stall never propagates combinationally upstream.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         head;
    logic         tail;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[head];

    // Occupancy and 1-bit wrapping pointers; flush empties the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage: written at the tail on an accepted, non-flushed push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push && !flush) begin
            mem[tail] <= in_data;
        end
    end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register: a 2-entry skid buffer of execute results plus
// the architectural condition flag and a forwarding tap on the head entry.
module ex_mem_skid_reg
    import nrisc_pkg::*;
#(
    parameter int DATA_W     = nrisc_pkg::DATA_W,
    parameter int REG_ADDR_W = nrisc_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_result,
    input  logic                  in_cond,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic                  in_set_cond,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [DATA_W-1:0]     out_store_data,
    output logic                  cond_flag,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0]     fwd_data
);

    ex_mem_entry_t in_entry;
    ex_mem_entry_t head_entry;
    logic          push;

    assign in_entry.result     = in_result;
    assign in_entry.rd         = in_rd;
    assign in_entry.reg_write  = in_reg_write;
    assign in_entry.mem_read   = in_mem_read;
    assign in_entry.mem_write  = in_mem_write;
    assign in_entry.store_data = in_store_data;

    assign push = in_valid & in_ready;

    skid_fifo2 #(
        .W(ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_entry)
    );

    assign out_result     = head_entry.result;
    assign out_rd         = head_entry.rd;
    assign out_reg_write  = head_entry.reg_write;
    assign out_mem_read   = head_entry.mem_read;
    assign out_mem_write  = head_entry.mem_write;
    assign out_store_data = head_entry.store_data;

    // Loads are not forwardable from here: their data only exists after MEM.
    assign fwd_valid = out_valid & head_entry.reg_write & ~head_entry.mem_read;
    assign fwd_rd    = head_entry.rd;
    assign fwd_data  = head_entry.result;

    // Flag updates at push so the branch right behind an SLT sees it;
    // a flushed push is squashed and leaves the flag alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_flag <= 1'b0;
        end else if (push && in_set_cond && !flush) begin
            cond_flag <= in_cond;
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed scenarios followed by random traffic,
// checked by a scoreboard queue that a negedge monitor pops and compares.
module tb_ex_mem_skid_reg;
    import nrisc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic       in_cond;
    logic [1:0] in_rd;
    logic       in_reg_write;
    logic       in_mem_read;
    logic       in_mem_write;
    logic [7:0] in_store_data;
    logic       in_set_cond;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [1:0] out_rd;
    logic       out_reg_write;
    logic       out_mem_read;
    logic       out_mem_write;
    logic [7:0] out_store_data;
    logic       cond_flag;
    logic       fwd_valid;
    logic [1:0] fwd_rd;
    logic [7:0] fwd_data;

    ex_mem_skid_reg dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_cond        (in_cond),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_store_data  (in_store_data),
        .in_set_cond    (in_set_cond),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_store_data (out_store_data),
        .cond_flag      (cond_flag),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    always #5 clk = ~clk;

    // Reference model: an in-order queue of at most two entries plus a flag.
    ex_mem_entry_t exp_q[$];
    logic          exp_flag;
    logic          popped;
    logic          mon_en;
    int            tests;
    int            fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare visible state against the model, then consume the
    // head entry if the memory stage takes it at the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            check("cond_flag", 32'(cond_flag), 32'(exp_flag));
            check("mem_rw_exclusive", 32'(out_mem_read & out_mem_write), 32'd0);
            if (exp_q.size() > 0) begin
                check("head_entry", 32'({out_result, out_rd, out_reg_write, out_mem_read,
                                         out_mem_write, out_store_data}), 32'(exp_q[0]));
                check("fwd_valid", 32'(fwd_valid),
                      32'(exp_q[0].reg_write && !exp_q[0].mem_read));
                check("fwd_rd", 32'(fwd_rd), 32'(exp_q[0].rd));
                check("fwd_data", 32'(fwd_data), 32'(exp_q[0].result));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    popped = 1'b1;
                end
            end else begin
                check("fwd_valid_empty", 32'(fwd_valid), 32'd0);
            end
        end
    end

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic cycle(input logic v, input logic [7:0] res, input logic [1:0] rd,
                         input logic rw, input logic mr, input logic mw,
                         input logic [7:0] sd, input logic sc, input logic c,
                         input logic rdy, input logic fl);
        ex_mem_entry_t e;
        int            occ;
        in_valid = v;  in_result = res; in_rd = rd; in_reg_write = rw;
        in_mem_read = mr; in_mem_write = mw; in_store_data = sd;
        in_set_cond = sc; in_cond = c; out_ready = rdy; flush = fl;
        @(posedge clk);
        #1;
        occ = exp_q.size() + (popped ? 1 : 0);
        popped = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else if (v && occ < 2) begin
            e.result = res; e.rd = rd; e.reg_write = rw; e.mem_read = mr;
            e.mem_write = mw; e.store_data = sd;
            exp_q.push_back(e);
            if (sc) exp_flag = c;
        end
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
        check({tag, "_cond_flag"}, 32'(cond_flag), 32'd0);
        check({tag, "_out_result"}, 32'(out_result), 32'd0);
        check({tag, "_out_rd"}, 32'(out_rd), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0; fails = 0; popped = 1'b0; mon_en = 1'b0; exp_flag = 1'b0;
        reset = 1'b1; in_valid = 0; in_result = 0; in_rd = 0; in_reg_write = 0;
        in_mem_read = 0; in_mem_write = 0; in_store_data = 0; in_set_cond = 0;
        in_cond = 0; out_ready = 0; flush = 0;
        #12;
        check_reset_state("por");
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // ADD 0x7F to r2 streamed with out_ready high.
        cycle(1, 8'h7F, 2'd2, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        cycle(1, 8'h80, 2'd1, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        cycle(1, 8'h01, 2'd3, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        idle(1);

        // Stall: fill with 0x11/0x22, hold, then drain in order.
        cycle(1, 8'h11, 2'd1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        cycle(1, 8'h22, 2'd2, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        cycle(1, 8'h33, 2'd3, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        idle(0);
        idle(1); idle(1); idle(1);

        // SLT sets the flag; a following ADD leaves it.
        cycle(1, 8'h01, 2'd1, 1, 0, 0, 8'h00, 1, 1, 1, 0);
        cycle(1, 8'h05, 2'd2, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        idle(1);

        // Flush a full buffer together with a flag-clearing SLT push.
        cycle(1, 8'hA1, 2'd1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        cycle(1, 8'hA2, 2'd2, 0, 0, 1, 8'h5A, 0, 0, 0, 0);
        cycle(1, 8'h00, 2'd3, 1, 0, 0, 8'h00, 1, 0, 0, 1);
        idle(1);

        // Load: visible on out_*, not forwardable.
        cycle(1, 8'h40, 2'd3, 1, 1, 0, 8'h00, 0, 0, 1, 0);
        idle(1); idle(1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 2));
            cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 2'($urandom),
                  1'($urandom), kind == 2'd1, kind == 2'd2, 8'($urandom),
                  1'($urandom_range(0, 9) < 3), 1'($urandom),
                  1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset mid-cycle with the buffer full and the flag set.
        cycle(1, 8'h01, 2'd1, 1, 0, 0, 8'h00, 1, 1, 0, 1);
        cycle(1, 8'h01, 2'd1, 1, 0, 0, 8'h00, 1, 1, 0, 0);
        cycle(1, 8'h02, 2'd2, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        check("pre_reset_full", 32'(in_ready), 32'd0);
        check("pre_reset_flag", 32'(cond_flag), 32'd1);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async");
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); exp_flag = 1'b0; popped = 1'b0;
        mon_en = 1'b1;
        cycle(1, 8'h99, 2'd2, 1, 0, 0, 8'h00, 0, 0, 1, 0);
        idle(1); idle(1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
